// File: rtl/forward_ctrl.sv
// -----------------------------------------------------------------------------
// forward_ctrl
//
// Forwarding and load-use hazard control for a classic five-stage pipeline.
// The block keeps its own shadow copy of the EX, MEM and WB destination
// information, so it needs only the ID-stage register fields as inputs.
//
// Operand selects (fwd_a_o / fwd_b_o) are registered: they are computed while
// an instruction sits in ID and are presented for the whole cycle that
// instruction occupies EX. stall_o is combinational and holds PC and IF/ID
// while a load in EX feeds the instruction in ID.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous, active-low reset
//   id_rs_i        rs of the ID instruction
//   id_rt_i        rt of the ID instruction
//   id_rd_i        write destination of the ID instruction
//   id_regwrite_i  ID instruction writes the register file
//   id_memread_i   ID instruction is a load
//   id_use_rt_i    ID instruction reads rt as a source
//   flush_i        squash the ID instruction (taken branch)
//   fwd_a_o        EX operand-A select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   fwd_b_o        EX operand-B select, same encoding
//   stall_o        hold PC and IF/ID this cycle
//   stall_cnt_o    saturating count of stall cycles (optional)
//
// Configuration
//   FORWARD_CTRL_STALL_CNT_EN  when defined, adds stall_cnt_o and its counter.
// -----------------------------------------------------------------------------
module forward_ctrl #(
    parameter int unsigned REG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             id_use_rt_i,
    input  logic             flush_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             stall_o
`ifdef FORWARD_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        SEL_RF    = 2'b00,
        SEL_EXMEM = 2'b01,
        SEL_MEMWB = 2'b10
    } fwd_sel_e;

    // Shadow pipeline entries.
    logic [REG_W-1:0] ex_rd_q,  ex_rd_d;
    logic             ex_rw_q,  ex_rw_d;
    logic             ex_mr_q,  ex_mr_d;
    logic [REG_W-1:0] mem_rd_q, mem_rd_d;
    logic             mem_rw_q, mem_rw_d;
    logic [REG_W-1:0] wb_rd_q,  wb_rd_d;
    logic             wb_rw_q,  wb_rw_d;

    fwd_sel_e fwd_a_q, fwd_a_d;
    fwd_sel_e fwd_b_q, fwd_b_d;

    logic bubble;

    // WB is tracked so the shadow pipeline mirrors the real one, but it is
    // never a forwarding source: the register file writes in the first half
    // of the cycle, so ID already reads the WB value.
    logic wb_unused;
    assign wb_unused = ^{wb_rd_q, wb_rw_q};

    // Most recent producer wins: EX is checked before MEM. Register 0 is
    // hard-wired to zero and is never forwarded.
    function automatic fwd_sel_e src_sel(input logic [REG_W-1:0] src,
                                         input logic [REG_W-1:0] ex_rd,
                                         input logic             ex_rw,
                                         input logic [REG_W-1:0] mem_rd,
                                         input logic             mem_rw);
        fwd_sel_e sel;
        sel = SEL_RF;
        if (src != '0) begin
            if (ex_rw && (ex_rd == src)) begin
                sel = SEL_EXMEM;
            end else if (mem_rw && (mem_rd == src)) begin
                sel = SEL_MEMWB;
            end
        end
        return sel;
    endfunction

    // Load-use hazard: the load's data is not available until after MEM, so
    // the dependent instruction must wait one cycle in ID.
    always_comb begin
        stall_o = 1'b0;
        if (ex_mr_q && (ex_rd_q != '0)) begin
            stall_o = (ex_rd_q == id_rs_i) || (id_use_rt_i && (ex_rd_q == id_rt_i));
        end
    end

    // A stall and a flush together still inject exactly one bubble.
    assign bubble = stall_o | flush_i;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        ex_rd_d  = '0;
        ex_rw_d  = 1'b0;
        ex_mr_d  = 1'b0;
        fwd_a_d  = SEL_RF;
        fwd_b_d  = SEL_RF;

        mem_rd_d = ex_rd_q;
        mem_rw_d = ex_rw_q;
        wb_rd_d  = mem_rd_q;
        wb_rw_d  = mem_rw_q;

        if (!bubble) begin
            ex_rd_d = id_rd_i;
            ex_rw_d = id_regwrite_i;
            ex_mr_d = id_memread_i;
            fwd_a_d = src_sel(id_rs_i, ex_rd_q, ex_rw_q, mem_rd_q, mem_rw_q);
            if (id_use_rt_i) begin
                fwd_b_d = src_sel(id_rt_i, ex_rd_q, ex_rw_q, mem_rd_q, mem_rw_q);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_rd_q  <= '0;
            ex_rw_q  <= 1'b0;
            ex_mr_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_rw_q <= 1'b0;
            wb_rd_q  <= '0;
            wb_rw_q  <= 1'b0;
            fwd_a_q  <= SEL_RF;
            fwd_b_q  <= SEL_RF;
        end else begin
            ex_rd_q  <= ex_rd_d;
            ex_rw_q  <= ex_rw_d;
            ex_mr_q  <= ex_mr_d;
            mem_rd_q <= mem_rd_d;
            mem_rw_q <= mem_rw_d;
            wb_rd_q  <= wb_rd_d;
            wb_rw_q  <= wb_rw_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
        end
    end

    assign fwd_a_o = fwd_a_q;
    assign fwd_b_o = fwd_b_q;

`ifdef FORWARD_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_forward_ctrl.sv
// -----------------------------------------------------------------------------
// tb_forward_ctrl
//
// Self-checking bench for forward_ctrl. A reference model keeps the history
// of the last two instructions issued into EX (newest first) and derives the
// expected stall and operand selects straight from the hazard rules. Directed
// instruction sequences are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_forward_ctrl;

    localparam int REG_W = 5;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [REG_W-1:0] id_rs_i, id_rt_i, id_rd_i;
    logic             id_regwrite_i, id_memread_i, id_use_rt_i, flush_i;
    logic [1:0]       fwd_a_o, fwd_b_o;
    logic             stall_o;
`ifdef FORWARD_CTRL_STALL_CNT_EN
    logic [15:0]      stall_cnt_o;
`endif

    forward_ctrl #(.REG_W(REG_W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .id_use_rt_i   (id_use_rt_i),
        .flush_i       (flush_i),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .stall_o       (stall_o)
`ifdef FORWARD_CTRL_STALL_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // One issued slot: destination, writes-register, is-load.
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             rw;
        logic             ld;
    } slot_t;

    slot_t issued[$];          // issued[0] = in EX, issued[1] = in MEM
    logic [1:0]  exp_a, exp_b, nxt_a, nxt_b;
    logic        exp_stall;
    int          exp_cnt;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        assert (got === want) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Which producer, if any, the value of register r must come from.
    function automatic logic [1:0] model_sel(input logic [REG_W-1:0] r);
        if (r == 0) return 2'b00;
        if (issued[0].rw && issued[0].rd == r) return 2'b01;
        if (issued[1].rw && issued[1].rd == r) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic model_stall();
        slot_t e;
        e = issued[0];
        return e.ld && e.rd != 0 &&
               (e.rd == id_rs_i || (id_use_rt_i && e.rd == id_rt_i));
    endfunction

    // Present an instruction in ID, then check the combinational stall.
    task automatic drive(input int rs, input int rt, input int rd, input bit rw,
                         input bit ld, input bit use_rt, input bit flush, input bit rst_n);
        @(negedge clk_i);
        id_rs_i       = REG_W'(rs);
        id_rt_i       = REG_W'(rt);
        id_rd_i       = REG_W'(rd);
        id_regwrite_i = rw;
        id_memread_i  = ld;
        id_use_rt_i   = use_rt;
        flush_i       = flush;
        rst_i         = rst_n;
        #1;
        exp_stall = model_stall();
        chk("stall", {15'd0, stall_o}, {15'd0, exp_stall});
        if (exp_stall || flush) begin
            nxt_a = 2'b00;
            nxt_b = 2'b00;
        end else begin
            nxt_a = model_sel(id_rs_i);
            nxt_b = use_rt ? model_sel(id_rt_i) : 2'b00;
        end
    endtask

    // Advance one clock, update the model, check the registered outputs.
    task automatic clock();
        slot_t s;
        @(posedge clk_i);
        if (!rst_i) begin
            issued = '{slot_t'(0), slot_t'(0)};
            exp_a = 2'b00;
            exp_b = 2'b00;
            exp_cnt = 0;
        end else begin
            if (exp_stall && exp_cnt < 65535) exp_cnt++;
            if (exp_stall || flush_i) s = '0;
            else s = '{rd: id_rd_i, rw: id_regwrite_i, ld: id_memread_i};
            issued.push_front(s);
            void'(issued.pop_back());
            exp_a = nxt_a;
            exp_b = nxt_b;
        end
        #1;
        chk("fwd_a", {14'd0, fwd_a_o}, {14'd0, exp_a});
        chk("fwd_b", {14'd0, fwd_b_o}, {14'd0, exp_b});
`ifdef FORWARD_CTRL_STALL_CNT_EN
        chk("stall_cnt", stall_cnt_o, 16'(exp_cnt));
`endif
    endtask

    // Ordinary register-register instruction: rd <= rs op rt.
    task automatic rr(input int rd, input int rs, input int rt);
        drive(rs, rt, rd, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        clock();
    endtask

    // Load: rt <= mem[rs + imm]; rt is a destination, not a source.
    task automatic lw(input int rd, input int rs);
        drive(rs, rd, rd, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        clock();
    endtask

    task automatic expect_sel(input string tag, input logic [1:0] a, input logic [1:0] b);
        chk({tag, "_a"}, {14'd0, fwd_a_o}, {14'd0, a});
        chk({tag, "_b"}, {14'd0, fwd_b_o}, {14'd0, b});
    endtask

    initial begin
        issued = '{slot_t'(0), slot_t'(0)};
        exp_a = 2'b00; exp_b = 2'b00; exp_cnt = 0; exp_stall = 1'b0;
        rst_i = 1'b0; flush_i = 1'b0;
        id_rs_i = '0; id_rt_i = '0; id_rd_i = '0;
        id_regwrite_i = 1'b0; id_memread_i = 1'b0; id_use_rt_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_stall", {15'd0, stall_o}, 16'd0);
        expect_sel("reset", 2'b00, 2'b00);
`ifdef FORWARD_CTRL_STALL_CNT_EN
        chk("reset_cnt", stall_cnt_o, 16'd0);
`endif

        // add $3,$1,$2 ; sub $4,$3,$5 -> EX/MEM forward on A only.
        rr(3, 1, 2);
        rr(4, 3, 5);
        expect_sel("ex_fwd", 2'b01, 2'b00);

        // add $3 ; unrelated ; or $6,$7,$3 -> MEM/WB forward on B.
        rr(3, 1, 2);
        rr(10, 11, 12);
        rr(6, 7, 3);
        expect_sel("mem_fwd", 2'b00, 2'b10);

        // lw $8 ; add $9,$8,$8 -> one stall, then MEM/WB on both.
        lw(8, 1);
        drive(8, 8, 9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("lu_stall", {15'd0, stall_o}, 16'd1);
        clock();
        drive(8, 8, 9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("lu_release", {15'd0, stall_o}, 16'd0);
        clock();
        expect_sel("lu_fwd", 2'b10, 2'b10);

        // add $5 ; sub $5 ; and $1,$5,$5 -> EX wins over MEM.
        rr(5, 1, 2);
        rr(5, 5, 3);
        rr(1, 5, 5);
        expect_sel("ex_wins", 2'b01, 2'b01);

        // Register 0 never forwards or stalls.
        rr(0, 1, 2);
        rr(7, 0, 0);
        expect_sel("r0_fwd", 2'b00, 2'b00);
        lw(0, 1);
        drive(0, 0, 9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("r0_stall", {15'd0, stall_o}, 16'd0);
        clock();

        // Reset while stalled clears everything in one cycle.
        lw(8, 1);
        drive(8, 8, 9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst_pre_stall", {15'd0, stall_o}, 16'd1);
        clock();
        chk("rst_stall", {15'd0, stall_o}, 16'd0);
        expect_sel("rst_sel", 2'b00, 2'b00);

        // Flushed load leaves no hazard behind.
        drive(1, 8, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        clock();
        expect_sel("flush_sel", 2'b00, 2'b00);
        drive(8, 8, 9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("flush_nostall", {15'd0, stall_o}, 16'd0);
        clock();

        // Stall and flush together: one bubble, selects 00.
        lw(8, 1);
        drive(8, 8, 9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("sf_stall", {15'd0, stall_o}, 16'd1);
        clock();
        expect_sel("sf_sel", 2'b00, 2'b00);

        // Randomized traffic on a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 31) != 0));
            clock();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
